// File: rtl/drum_step_sequencer_if.sv
// ---------------------------------------------------------------------------
// drum_step_sequencer_if
// Control/status bundle between the PS-side control registers (master) and
// the drum step sequencer (slave).
//   run          master->slave  1 = sequencer running
//   tempo_div    master->slave  samples per step (0 behaves as 1)
//   cfg_we       master->slave  one-cycle pattern row write strobe
//   cfg_voice    master->slave  pattern row to write
//   cfg_pattern  master->slave  row data, bit s = fire at step s
//   manual_trig  master->slave  one-cycle per-voice hit requests
//   trig_out     slave->master  per-voice trigger level to the voices
//   step_idx     slave->master  current step
//   step_strobe  slave->master  one-cycle pulse on each step advance
// ---------------------------------------------------------------------------
interface drum_step_sequencer_if #(
    parameter int NUM_VOICES = 4,
    parameter int NUM_STEPS  = 16,
    parameter int TEMPO_BITS = 16
);
    localparam int VW = $clog2(NUM_VOICES);
    localparam int SW = $clog2(NUM_STEPS);

    logic                  run;
    logic [TEMPO_BITS-1:0] tempo_div;
    logic                  cfg_we;
    logic [VW-1:0]         cfg_voice;
    logic [NUM_STEPS-1:0]  cfg_pattern;
    logic [NUM_VOICES-1:0] manual_trig;
    logic [NUM_VOICES-1:0] trig_out;
    logic [SW-1:0]         step_idx;
    logic                  step_strobe;

    modport master (
        output run, tempo_div, cfg_we, cfg_voice, cfg_pattern, manual_trig,
        input  trig_out, step_idx, step_strobe
    );

    modport slave (
        input  run, tempo_div, cfg_we, cfg_voice, cfg_pattern, manual_trig,
        output trig_out, step_idx, step_strobe
    );
endinterface

// File: rtl/drum_step_sequencer.sv
// ---------------------------------------------------------------------------
// drum_step_sequencer
// Pattern-driven trigger scheduler for the one-shot drum voices. Divides the
// sample rate (pblrc) into steps, fires voices whose pattern bit is set for
// the new step, and stretches each hit to TRIG_SAMPLES sample periods so the
// pblrc-clocked debouncer in each voice sees it.
// Ports:
//   mclk   master clock (256x sample rate)
//   rst    asynchronous reset, active low
//   pblrc  sample-rate LR clock, asynchronous, synchronized here
//   bus    control/status bundle (slave side), see drum_step_sequencer_if
// ---------------------------------------------------------------------------
module drum_step_sequencer #(
    parameter int NUM_VOICES   = 4,
    parameter int NUM_STEPS    = 16,
    parameter int TEMPO_BITS   = 16,
    parameter int TRIG_SAMPLES = 4
) (
    input  logic mclk,
    input  logic rst,
    input  logic pblrc,
    drum_step_sequencer_if.slave bus
);
    localparam int SW = $clog2(NUM_STEPS);
    localparam int HW = 8;

    typedef enum logic {IDLE, RUN} state_e;

    state_e                          state_q, state_d;
    logic [2:0]                      sync_q;
    logic                            tick_q;
    logic [TEMPO_BITS-1:0]           samp_cnt_q, samp_cnt_d;
    logic [SW-1:0]                   step_q, step_d;
    logic                            first_q, first_d;
    logic                            strobe_q;
    logic                            fire;
    logic [TEMPO_BITS-1:0]           limit;
    logic [NUM_VOICES-1:0]           pend_q, pend_d;
    logic [NUM_VOICES-1:0][HW-1:0]   hold_q, hold_d;
    logic [NUM_VOICES-1:0][NUM_STEPS-1:0] pattern_q;

    // Two synchronizer stages, a third stage for edge history, and a
    // registered rising-edge pulse: tick lands 3 mclk after a pblrc rise.
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            tick_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], pblrc};
            tick_q <= sync_q[1] & ~sync_q[2];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.run)  state_d = RUN;
            RUN:     if (!bus.run) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // max(tempo_div,1)-1; a >= compare keeps a mid-step tempo drop from
    // running the counter past its terminal value.
    assign limit = (bus.tempo_div == '0) ? '0 : bus.tempo_div - 1'b1;

    always_comb begin
        samp_cnt_d = samp_cnt_q;
        step_d     = step_q;
        first_d    = first_q;
        fire       = 1'b0;
        if (state_q == IDLE) begin
            samp_cnt_d = '0;
            step_d     = '0;
            first_d    = 1'b1;
        end else if (tick_q) begin
            if (first_q) begin
                fire    = 1'b1;
                first_d = 1'b0;
            end else if (samp_cnt_q >= limit) begin
                samp_cnt_d = '0;
                step_d     = (step_q == SW'(NUM_STEPS - 1)) ? '0 : step_q + 1'b1;
                fire       = 1'b1;
            end else begin
                samp_cnt_d = samp_cnt_q + 1'b1;
            end
        end
    end

    // Per-voice hold counters. A reload while still nonzero keeps the
    // trigger high without a new edge, so close hits merge by design.
    always_comb begin
        hold_d = hold_q;
        pend_d = pend_q;
        for (int v = 0; v < NUM_VOICES; v++) begin
            pend_d[v] = pend_q[v] | bus.manual_trig[v];
            if ((fire && pattern_q[v][step_d]) ||
                (tick_q && (pend_q[v] || bus.manual_trig[v]))) begin
                hold_d[v] = HW'(TRIG_SAMPLES);
            end else if (tick_q && hold_q[v] != '0) begin
                hold_d[v] = hold_q[v] - 1'b1;
            end
            if (tick_q) pend_d[v] = 1'b0;
        end
    end

    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            samp_cnt_q <= '0;
            step_q     <= '0;
            first_q    <= 1'b0;
            strobe_q   <= 1'b0;
            pend_q     <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            samp_cnt_q <= samp_cnt_d;
            step_q     <= step_d;
            first_q    <= first_d;
            strobe_q   <= fire;
            pend_q     <= pend_d;
            hold_q     <= hold_d;
        end
    end

    // Pattern rows are read combinationally by fire, so a write landing in
    // the same cycle as a fire is seen only from the next cycle on.
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            pattern_q <= '0;
        end else if (bus.cfg_we && int'(bus.cfg_voice) < NUM_VOICES) begin
            pattern_q[bus.cfg_voice] <= bus.cfg_pattern;
        end
    end

    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            bus.trig_out[v] = (hold_q[v] != '0);
        end
    end

    assign bus.step_idx    = step_q;
    assign bus.step_strobe = strobe_q;
endmodule

// File: tb/tb_drum_step_sequencer.sv
// ---------------------------------------------------------------------------
// tb_drum_step_sequencer
// Directed bench for drum_step_sequencer. pblrc is generated one sample at a
// time by task samp so the tick cycle is known exactly: pblrc rises after
// posedge P0, tick is high between P3 and P4, results are visible after P4.
// ---------------------------------------------------------------------------
module tb_drum_step_sequencer;
    localparam int NV = 4;
    localparam int NS = 16;
    localparam int TB = 16;
    localparam int TS = 4;

    logic mclk;
    logic rst;
    logic pblrc;

    int n_cmp = 0;
    int n_bad = 0;

    logic [NV-1:0] trg_pre, trg_post;
    logic          strb, strb_late;

    drum_step_sequencer_if #(.NUM_VOICES(NV), .NUM_STEPS(NS), .TEMPO_BITS(TB)) bus ();

    drum_step_sequencer #(
        .NUM_VOICES(NV), .NUM_STEPS(NS), .TEMPO_BITS(TB), .TRIG_SAMPLES(TS)
    ) dut (
        .mclk  (mclk),
        .rst   (rst),
        .pblrc (pblrc),
        .bus   (bus)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

    // One sample period. we/v/pat and man are applied during the tick cycle.
    task automatic samp(input logic we, input logic [1:0] v,
                        input logic [NS-1:0] pat, input logic [NV-1:0] man);
        @(posedge mclk); #1 pblrc = 1'b1;
        @(posedge mclk);
        @(posedge mclk);
        @(posedge mclk); #1;
        trg_pre         = bus.trig_out;
        bus.cfg_we      = we;
        bus.cfg_voice   = v;
        bus.cfg_pattern = pat;
        bus.manual_trig = man;
        @(posedge mclk); #1;
        bus.cfg_we      = 1'b0;
        bus.manual_trig = '0;
        strb            = bus.step_strobe;
        trg_post        = bus.trig_out;
        pblrc           = 1'b0;
        @(posedge mclk); #1;
        strb_late       = bus.step_strobe;
        repeat (3) @(posedge mclk);
        #1;
    endtask

    task automatic tk();
        samp(1'b0, 2'd0, '0, '0);
    endtask

    task automatic wr(input logic [1:0] v, input logic [NS-1:0] pat);
        @(posedge mclk); #1;
        bus.cfg_we = 1'b1; bus.cfg_voice = v; bus.cfg_pattern = pat;
        @(posedge mclk); #1;
        bus.cfg_we = 1'b0;
    endtask

    task automatic man_pulse(input logic [NV-1:0] m);
        @(posedge mclk); #1 bus.manual_trig = m;
        @(posedge mclk); #1 bus.manual_trig = '0;
    endtask

    task automatic set_run(input logic r);
        @(posedge mclk); #1 bus.run = r;
        repeat (2) @(posedge mclk);
        #1;
    endtask

    task automatic stop_drain();
        set_run(1'b0);
        repeat (6) tk();
    endtask

    task automatic test_reset();
        int act;
        rst = 1'b0;
        repeat (5) @(posedge mclk);
        #1;
        n_cmp++; if (bus.trig_out !== '0) begin n_bad++; $display("FAIL reset_trig got=%b want=0", bus.trig_out); end
        n_cmp++; if (bus.step_idx !== '0) begin n_bad++; $display("FAIL reset_step got=%0d want=0", bus.step_idx); end
        n_cmp++; if (bus.step_strobe !== 1'b0) begin n_bad++; $display("FAIL reset_strobe got=%b want=0", bus.step_strobe); end
        rst = 1'b1;
        // tempo_div=0 behaves as 1: one step per tick.
        bus.tempo_div = '0;
        set_run(1'b1);
        act = 0;
        for (int t = 0; t < 64; t++) begin
            tk();
            if (trg_pre != '0 || trg_post != '0 || bus.trig_out != '0) act++;
        end
        n_cmp++; if (act !== 0) begin n_bad++; $display("FAIL reset_quiet got=%0d active ticks want=0", act); end
        n_cmp++; if (bus.step_idx !== 4'd15) begin n_bad++; $display("FAIL tempo0_step got=%0d want=15", bus.step_idx); end
        stop_drain();
    endtask

    task automatic test_basic_loop();
        logic [NV-1:0] et;
        wr(2'd0, 16'h0001);
        wr(2'd1, 16'h0101);
        bus.tempo_div = 16'd3;
        set_run(1'b1);
        for (int t = 0; t <= 50; t++) begin
            tk();
            et = '0;
            et[0] = ((t % 48) < 4);
            et[1] = ((t % 24) < 4);
            n_cmp++; if (strb !== (t % 3 == 0)) begin n_bad++; $display("FAIL basic_strobe t=%0d got=%b want=%b", t, strb, (t % 3 == 0)); end
            n_cmp++; if (bus.step_idx !== 4'((t / 3) % 16)) begin n_bad++; $display("FAIL basic_step t=%0d got=%0d want=%0d", t, bus.step_idx, (t / 3) % 16); end
            n_cmp++; if (bus.trig_out !== et) begin n_bad++; $display("FAIL basic_trig t=%0d got=%b want=%b", t, bus.trig_out, et); end
            if (t == 0) begin
                n_cmp++; if (strb_late !== 1'b0) begin n_bad++; $display("FAIL strobe_width got=%b want=0", strb_late); end
            end
        end
        wr(2'd0, '0);
        wr(2'd1, '0);
        stop_drain();
    endtask

    task automatic test_wrap_tempo();
        bus.tempo_div = 16'd1;
        set_run(1'b1);
        for (int t = 0; t <= 16; t++) begin
            tk();
            if (t == 15) begin
                n_cmp++; if (bus.step_idx !== 4'd15) begin n_bad++; $display("FAIL wrap_pre got=%0d want=15", bus.step_idx); end
            end
        end
        n_cmp++; if (bus.step_idx !== 4'd0 || strb !== 1'b1) begin n_bad++; $display("FAIL wrap_zero got=%0d/%b want=0/1", bus.step_idx, strb); end
        set_run(1'b0);
        bus.tempo_div = 16'd8;
        set_run(1'b1);
        repeat (6) tk();   // first tick fires step 0, then samp_cnt climbs to 5
        n_cmp++; if (bus.step_idx !== 4'd0) begin n_bad++; $display("FAIL tempo_hold got=%0d want=0", bus.step_idx); end
        bus.tempo_div = 16'd2;
        tk();
        n_cmp++; if (bus.step_idx !== 4'd1 || strb !== 1'b1) begin n_bad++; $display("FAIL tempo_drop got=%0d/%b want=1/1", bus.step_idx, strb); end
        tk();
        n_cmp++; if (bus.step_idx !== 4'd1 || strb !== 1'b0) begin n_bad++; $display("FAIL tempo_mid got=%0d/%b want=1/0", bus.step_idx, strb); end
        tk();
        n_cmp++; if (bus.step_idx !== 4'd2 || strb !== 1'b1) begin n_bad++; $display("FAIL tempo_next got=%0d/%b want=2/1", bus.step_idx, strb); end
        stop_drain();
    endtask

    task automatic test_manual();
        int hi;
        man_pulse(4'b0100);
        tk();
        n_cmp++; if (trg_pre[2] !== 1'b0 || trg_post[2] !== 1'b1) begin n_bad++; $display("FAIL man_rise got=%b%b want=01", trg_pre[2], trg_post[2]); end
        hi = int'(bus.trig_out[2]);
        tk();
        hi += int'(bus.trig_out[2]);
        man_pulse(4'b0100);
        for (int i = 0; i < 8; i++) begin
            tk();
            hi += int'(bus.trig_out[2]);
        end
        n_cmp++; if (hi !== 6) begin n_bad++; $display("FAIL man_retrig got=%0d ticks want=6", hi); end
        n_cmp++; if (bus.trig_out !== '0) begin n_bad++; $display("FAIL man_end got=%b want=0", bus.trig_out); end
        // Pulse coinciding with the tick is serviced by that tick.
        samp(1'b0, 2'd0, '0, 4'b0010);
        n_cmp++; if (trg_post !== 4'b0010) begin n_bad++; $display("FAIL man_same got=%b want=0010", trg_post); end
        repeat (5) tk();
        // Two pulses before one tick merge into one 4-tick hit.
        man_pulse(4'b1000);
        man_pulse(4'b1000);
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            tk();
            hi += int'(bus.trig_out[3]);
        end
        n_cmp++; if (hi !== TS) begin n_bad++; $display("FAIL man_merge got=%0d ticks want=%0d", hi, TS); end
    endtask

    task automatic test_collision();
        bus.tempo_div = 16'd1;
        set_run(1'b1);
        repeat (5) tk();
        samp(1'b1, 2'd3, 16'hFFFF, '0);   // fire on step 5 with concurrent write
        n_cmp++; if (bus.step_idx !== 4'd5 || bus.trig_out[3] !== 1'b0) begin n_bad++; $display("FAIL coll_old got=%0d/%b want=5/0", bus.step_idx, bus.trig_out[3]); end
        tk();
        n_cmp++; if (bus.step_idx !== 4'd6 || bus.trig_out[3] !== 1'b1) begin n_bad++; $display("FAIL coll_new got=%0d/%b want=6/1", bus.step_idx, bus.trig_out[3]); end
        // With NUM_VOICES=4 the 2-bit cfg_voice cannot encode row 4, so the
        // out-of-range write case has no stimulus at this configuration.
        wr(2'd3, '0);
        stop_drain();
    endtask

    task automatic test_stop_reset();
        wr(2'd0, 16'h0001);
        bus.tempo_div = 16'd4;
        set_run(1'b1);
        tk();
        n_cmp++; if (bus.trig_out !== 4'b0001 || strb !== 1'b1) begin n_bad++; $display("FAIL stop_fire got=%b/%b want=0001/1", bus.trig_out, strb); end
        tk();
        set_run(1'b0);
        n_cmp++; if (bus.trig_out[0] !== 1'b1) begin n_bad++; $display("FAIL stop_keep got=%b want=1", bus.trig_out[0]); end
        tk();
        tk();
        n_cmp++; if (bus.trig_out[0] !== 1'b1) begin n_bad++; $display("FAIL stop_t3 got=%b want=1", bus.trig_out[0]); end
        tk();
        n_cmp++; if (bus.trig_out[0] !== 1'b0 || strb !== 1'b0) begin n_bad++; $display("FAIL stop_done got=%b/%b want=0/0", bus.trig_out[0], strb); end
        set_run(1'b1);
        tk();
        n_cmp++; if (bus.step_idx !== 4'd0 || strb !== 1'b1 || bus.trig_out[0] !== 1'b1) begin n_bad++; $display("FAIL restart got=%0d/%b/%b want=0/1/1", bus.step_idx, strb, bus.trig_out[0]); end
        tk();
        @(posedge mclk); #1 rst = 1'b0;
        #1;
        n_cmp++; if (bus.trig_out !== '0) begin n_bad++; $display("FAIL async_rst got=%b want=0", bus.trig_out); end
        repeat (2) @(posedge mclk);
        #1 rst = 1'b1;
        // run is still 1: the first tick after reset fires step 0 of a cleared pattern.
        set_run(1'b1);
        tk();
        n_cmp++; if (bus.trig_out !== '0 || strb !== 1'b1) begin n_bad++; $display("FAIL rst_pattern got=%b/%b want=0000/1", bus.trig_out, strb); end
        stop_drain();
    endtask

    initial begin
        rst             = 1'b0;
        pblrc           = 1'b0;
        bus.run         = 1'b0;
        bus.tempo_div   = '0;
        bus.cfg_we      = 1'b0;
        bus.cfg_voice   = '0;
        bus.cfg_pattern = '0;
        bus.manual_trig = '0;
        test_reset();
        test_basic_loop();
        test_wrap_tempo();
        test_manual();
        test_collision();
        test_stop_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/drum_step_sequencer.md
# drum_step_sequencer

Pattern-driven trigger scheduler for the one-shot drum voices (hihat, kick, etc.). Holds an on/off pattern per voice, divides the sample rate into steps, and drives each voice's `trig` input. Each trigger is held long enough for the voice's pblrc-clocked debouncer to register it. Sits between the PS-side control registers and the `trig` pins of the `src_oneshot_*` instances, in the `mclk` domain.

## Interface
- `NUM_VOICES`, 4 — number of drum voices driven.
- `NUM_STEPS`, 16 — steps per pattern loop.
- `TEMPO_BITS`, 16 — width of the samples-per-step divider.
- `TRIG_SAMPLES`, 4 — trigger high time in sample periods; legal range is 1..255.

- `mclk`  in  1  master clock (256x sample rate).
- `rst`  in  1  asynchronous reset, active-low.
- `pblrc`  in  1  sample-rate LR clock; asynchronous to this block's logic and synchronized internally.
- `run`  in  1  level; 1 = sequencer running, 0 = stopped.
- `tempo_div`  in  TEMPO_BITS  samples per step; a value of 0 is treated as 1.
- `cfg_we`  in  1  one-cycle pattern write strobe.
- `cfg_voice`  in  $clog2(NUM_VOICES)  pattern row to write.
- `cfg_pattern`  in  NUM_STEPS  row data; bit s = fire at step s.
- `manual_trig`  in  NUM_VOICES  one-cycle pulses requesting an immediate hit.
- `trig_out`  out  NUM_VOICES  per-voice trigger level to the voices.
- `step_idx`  out  $clog2(NUM_STEPS)  current step.
- `step_strobe`  out  1  one-cycle pulse on every step advance.

## Operation
- **Sample tick.** `pblrc` passes through a 2-FF synchronizer, then a rising-edge detector. The detector output `tick` is a 1-cycle pulse, once per sample.
- **FSM states.** IDLE and RUN. Reset state is IDLE.
  - IDLE -> RUN when `run`=1.
  - RUN -> IDLE when `run`=0. The transition is the next `mclk`, not aligned to `tick`.
- **IDLE behaviour.**
  - `samp_cnt`=0, `step_idx`=0, `first`=1.
  - No pattern fires occur.
  - Manual triggers still work.
- **RUN, on each `tick`:**
  - If `first`=1: fire step 0 and clear `first`.
  - Else if `samp_cnt` >= max(`tempo_div`,1)-1: clear `samp_cnt`, set `step_idx` = (`step_idx`+1) mod NUM_STEPS (NUM_STEPS-1 wraps to 0), and fire the new step.
  - Else: increment `samp_cnt`.
  - The >= compare means that lowering `tempo_div` mid-step advances on the next tick and never wraps the counter.
- **Fire.**
  - Assert `step_strobe`.
  - For each voice v with `pattern[v][step_idx_new]`=1, load `hold[v]`=TRIG_SAMPLES.
- **Manual triggers.**
  - A `manual_trig[v]` pulse sets a pending bit.
  - At the next `tick`, in any state, the pending bit loads `hold[v]`=TRIG_SAMPLES and is cleared.
  - A pulse arriving in the same cycle as `tick` is serviced in that tick.
  - Multiple pulses before a tick merge into one hit.
- **Hold counters.**
  - `trig_out[v]` = (`hold[v]` != 0).
  - Each `tick` that does not reload `hold[v]` decrements it.
  - A retrigger while `hold[v]`!=0 reloads the counter, so the trigger stays high with no new rising edge. This is intentional: a hit within TRIG_SAMPLES of the previous one is absorbed.
- **Pattern RAM.**
  - NUM_VOICES x NUM_STEPS flops, cleared by reset.
  - `cfg_we` writes `cfg_pattern` to row `cfg_voice`. Writes with `cfg_voice` >= NUM_VOICES are ignored.
  - If a write and a fire land in the same cycle, the fire uses the old row contents and the write takes effect the following cycle.
- **`run` dropping mid-step.**
  - The FSM goes to IDLE immediately.
  - Active `hold` counters keep decrementing on ticks, so no trigger is truncated.
  - The next RUN restarts at step 0.

## Timing
- **Reset values (`rst`=0).** `trig_out`=0, `step_idx`=0, `step_strobe`=0; all internal counters, pending bits and pattern bits are 0.
- **Sync latency.** A `pblrc` rising edge produces `tick` 3 `mclk` cycles later: 2 synchronizer stages plus the edge register.
- **Outputs after a tick.** With `tick` high in cycle T, the new `step_idx`, `step_strobe`=1 and any new `trig_out` rising edges are all registered and visible in T+1. `step_strobe` is low in T+2.
- **Trigger width.** `trig_out` stays high for exactly TRIG_SAMPLES ticks: it falls in the cycle after the TRIG_SAMPLES-th subsequent tick.
- **Step period.** Exactly max(`tempo_div`,1) ticks between `step_strobe` pulses.
- **Async reset mid-operation.** All state clears immediately, and `trig_out` falls with no glitch extension.

## Test plan
- **Reset.**
  - Stimulus: assert `rst`=0 for 5 cycles.
  - Required: `trig_out`=0 and `step_idx`=0. Then with `run`=1 and all patterns 0, no `trig_out` activity for 64 ticks.
- **Basic loop.**
  - Stimulus: pattern[0]=16'h0001, pattern[1]=16'h0101, `tempo_div`=3, `run`=1.
  - Required: voice0 fires at steps 0 and 16. Voice1 fires at steps 0 and 8, i.e. ticks 0, 24, 48. Each hit is high for 4 ticks, and `step_strobe` occurs every 3 ticks.
- **Wrap and tempo change.**
  - Stimulus: NUM_STEPS=16 with `tempo_div`=1. Change `tempo_div` 8->2 while `samp_cnt`=5.
  - Required: `step_idx` goes 15->0. After the tempo change, the step advances on the very next tick.
- **Manual trigger and retrigger.**
  - Stimulus: `manual_trig[2]` pulse in IDLE, then a second pulse 2 ticks later.
  - Required: `trig_out[2]` rises 1 cycle after the next tick and stays high for 2+4=6 ticks total.
- **Write/fire collision.**
  - Stimulus: `cfg_we` writes pattern[3]=16'hFFFF in the same cycle as a fire on step 5, with the old pattern[3]=0.
  - Required: no hit at step 5, hit at step 6. A write with `cfg_voice`=4 (out of range when NUM_VOICES=4) changes nothing.
- **Stop and async reset.**
  - Stimulus: drop `run` 1 tick after a fire, then reassert.
  - Required: the active trigger completes its 4 ticks and the restart fires step 0. Asserting `rst` mid-trigger clears `trig_out` within the same cycle.
